// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the sequential divider.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Trial subtraction for one restoring-division step.
// The operands are one bit wider than the divider's operand width.
// borrow=1 means the divisor did not fit, so the caller keeps the shifted remainder.
// Only the low WIDTH bits of the difference are returned. That is enough because
// the difference is kept only when there is no borrow, and in that case it is always below the divisor.
module trial_sub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   x,
   input  logic [WIDTH:0]   y,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   assign borrow = (x < y);
   assign diff   = WIDTH'(x - y);

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready high; start captures operands
//   RUN   | one restoring step per edge; counter holds steps remaining
//   DONE  | done pulse for one cycle; q/r/div_by_zero valid
//
// A zero divisor skips RUN. It produces q = all ones and r = a.
module seq_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] dvd_reg;
   logic [WIDTH-1:0] dvs_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [CW-1:0]    cnt;
   logic             dbz_reg;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};

   trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
      .x      (rem_shift),
      .y      ({1'b0, dvs_reg}),
      .diff   (diff),
      .borrow (borrow)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = (b == '0) ? DONE : RUN;
         end
         RUN: begin
            if (cnt == CW'(1)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, restoring step and step counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_reg <= '0;
         dvs_reg <= '0;
         rem_reg <= '0;
         quo_reg <= '0;
         cnt     <= '0;
         dbz_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_reg <= a;
                  dvs_reg <= b;
                  dbz_reg <= (b == '0);
                  if (b == '0) begin
                     quo_reg <= '1;
                     rem_reg <= a;
                     cnt     <= '0;
                  end else begin
                     quo_reg <= '0;
                     rem_reg <= '0;
                     cnt     <= CW'(WIDTH);
                  end
               end
            end
            RUN: begin
               rem_reg <= borrow ? rem_shift[WIDTH-1:0] : diff;
               quo_reg <= (quo_reg << 1) | WIDTH'(!borrow);
               dvd_reg <= dvd_reg << 1;
               cnt     <= cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign q           = quo_reg;
   assign r           = rem_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       ready;
   logic       done;
   logic [3:0] q;
   logic [3:0] r;
   logic       div_by_zero;

   int n_vec;
   int n_err;

   seq_divider #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .ready       (ready),
      .done        (done),
      .q           (q),
      .r           (r),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] ref_q(input logic [3:0] x, input logic [3:0] y);
      return (y == 0) ? 4'hF : 4'(int'(x) / int'(y));
   endfunction

   function automatic logic [3:0] ref_r(input logic [3:0] x, input logic [3:0] y);
      return (y == 0) ? x : 4'(int'(x) % int'(y));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raise start with the given operands at a falling edge.
   // The request is then accepted on the next rising edge.
   task automatic do_start(input logic [3:0] ta, input logic [3:0] tb);
      @(negedge clk);
      a     = ta;
      b     = tb;
      start = 1'b1;
   endtask

   // Count rising edges, starting with the accepting edge, until done is seen.
   // Unless hold is set, start is dropped and the operands are scrambled after the first edge.
   task automatic wait_done(input bit hold, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1 && !hold) begin
            start = 1'b0;
            a     = 4'($urandom);
            b     = 4'($urandom);
         end
         if (!done) chk("ready_low_busy", 32'(ready), 32'd0);
      end while (!done && n < 40);
   endtask

   task automatic chk_result(input string tag, input logic [3:0] ta, input logic [3:0] tb, input int n);
      chk({tag, "_lat"}, 32'(n), (tb == 0) ? 32'd1 : 32'd5);
      chk({tag, "_q"}, 32'(q), 32'(ref_q(ta, tb)));
      chk({tag, "_r"}, 32'(r), 32'(ref_r(ta, tb)));
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(tb == 0));
   endtask

   // Step into the IDLE cycle that follows DONE.
   task automatic step_idle(input string tag);
      @(posedge clk);
      #1;
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
   endtask

   task automatic run_div(input string tag, input logic [3:0] ta, input logic [3:0] tb);
      int n;
      do_start(ta, tb);
      wait_done(1'b0, n);
      chk_result(tag, ta, tb, n);
      step_idle(tag);
   endtask

   initial begin
      int n;
      logic [3:0] ra, rb;
      n_vec = 0;
      n_err = 0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      rst_n = 1'b0;

      #12;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_r", 32'(r), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      run_div("d_10_3", 4'd10, 4'd3);
      run_div("d_15_1", 4'd15, 4'd1);
      run_div("d_6_10", 4'd6, 4'd10);
      run_div("d_0_7", 4'd0, 4'd7);
      run_div("d_9_0", 4'd9, 4'd0);
      run_div("d_8_2", 4'd8, 4'd2);

      // start held through RUN is ignored, then accepted right after DONE
      do_start(4'd10, 4'd3);
      @(posedge clk);
      #1;
      a = 4'd12;
      b = 4'd5;
      n = 1;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk_result("hold_10_3", 4'd10, 4'd3, n);
      @(posedge clk);
      #1;
      chk("hold_idle_ready", 32'(ready), 32'd1);
      wait_done(1'b0, n);
      chk_result("hold_12_5", 4'd12, 4'd5, n);
      step_idle("hold_12_5");

      // Reset during RUN aborts the operation
      do_start(4'd14, 4'd3);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_q", 32'(q), 32'd0);
      chk("abort_r", 32'(r), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", 32'(done), 32'd0);
      end
      run_div("abort_14_3", 4'd14, 4'd3);

      // Exhaustive sweep
      for (int ai = 0; ai < 16; ai++)
         for (int bi = 0; bi < 16; bi++)
            run_div("sweep", 4'(ai), 4'(bi));

      // Random back-to-back operations
      for (int k = 0; k < 40; k++) begin
         ra = 4'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
         run_div("rand", ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 4, the operand, quotient and remainder width.
REQ-002 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a division; sampled on the rising edge.
REQ-005 Port: a  input  WIDTH  dividend, unsigned.
REQ-006 Port: b  input  WIDTH  divisor, unsigned.
REQ-007 Port: ready  output  1  high only in IDLE; block can accept start.
REQ-008 Port: done  output  1  one-cycle pulse; q/r/div_by_zero are valid.
REQ-009 Port: q  output  WIDTH  quotient.
REQ-010 Port: r  output  WIDTH  remainder.
REQ-011 Port: div_by_zero  output  1  the last division had b == 0.

Function
REQ-012 The block SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, a rising edge SHALL capture a and b into internal registers, clear the partial remainder, load the iteration counter with WIDTH, and move to RUN; the one exception is REQ-017.
REQ-014 In RUN, each rising edge SHALL perform one restoring step, MSB first:
- shift the remainder left by one, bringing in the next dividend bit;
- trial-subtract b at WIDTH+1 bits;
- if no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0;
- decrement the counter.
REQ-015 After the WIDTH-th RUN step the FSM SHALL enter DONE; done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-016 Latency SHALL be: done is high in the cycle after the (WIDTH+1)-th rising edge counted from and including the start-accepting edge (WIDTH=4: 5 edges).
REQ-017 If the captured b == 0, the FSM SHALL go from IDLE directly to DONE with q = all ones, r = a and div_by_zero=1; done is high after 1 edge.
REQ-018 div_by_zero SHALL be cleared when the next start is accepted.
REQ-019 q and r SHALL hold their final values from DONE until the next accepted start; they need not be stable during RUN.
REQ-020 start SHALL be ignored in RUN and DONE; a and b may change freely after capture without affecting the result.
REQ-021 A start in the IDLE cycle that immediately follows DONE SHALL be accepted (back-to-back operation).
REQ-022 Results SHALL satisfy a == q*b + r and r < b for all b != 0, over the full unsigned range.

Reset
REQ-023 rst_n low SHALL immediately force:
- state IDLE;
- ready=1;
- done=0, q=0, r=0, div_by_zero=0;
- counter and operand registers to 0.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse is produced for it.
REQ-025 After rst_n deassertion, the first start SHALL be accepted on the next rising edge.

Structure
REQ-026 A shared package alu_pkg SHALL hold the default WIDTH constant and the FSM state typedef (IDLE, RUN, DONE).
REQ-027 One sub-module, trial_sub, SHALL implement the (WIDTH+1)-bit subtract with a borrow output; it is instantiated once, and the FSM/datapath stays in seq_divider.

Verification
REQ-028 a=10, b=3, start for 1 cycle -> done after 5 edges, q=3, r=1, div_by_zero=0, ready low between start and done.
REQ-029 a=15, b=1 -> q=15, r=0; a=6, b=10 -> q=0, r=6; a=0, b=7 -> q=0, r=0.
REQ-030 a=9, b=0 -> done after 1 edge, q=15, r=9, div_by_zero=1; the next start with a=8, b=2 -> q=4, r=0, div_by_zero=0.
REQ-031 Start at 10/3, then start held high with a=12, b=5 during RUN -> result remains q=3, r=1; the held start is accepted in the IDLE cycle after done, giving q=2, r=2.
REQ-032 Start at 14/3, rst_n pulsed low at the 2nd RUN edge -> outputs 0 immediately, no done pulse, ready=1; a fresh 14/3 -> q=4, r=2.
REQ-033 Exhaustive sweep of all 256 (a,b) pairs at WIDTH=4, compared against a reference model, including div_by_zero for b=0 -> zero mismatches.
